modbus_rtu_frame_rx: RTL

Modbus RTU frame receiver sitting directly downstream of the Modbus UART controller's receive byte interface. It consumes received bytes and delimits frames by the RTU 3.5-character silence rule. It checks CRC-16/MODBUS and the slave address, then presents each accepted frame in an internal buffer to the Modbus protocol engine until that engine acknowledges it.

---
 rtl/modbus_rtu_frame_rx_if.sv | 31 +++
 rtl/modbus_rtu_frame_rx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/modbus_rtu_frame_rx_if.sv
// Byte-side and engine-side signals of the Modbus RTU frame receiver.
// Names are seen from the receiver: i_* flow into it, o_* flow out of it.
// The receiver connects through the slave modport; the UART controller and
// protocol engine (or a bench standing in for them) use the master modport.
interface modbus_rtu_frame_rx_if #(
  parameter int BUF_AW = 8
);
  logic [7:0]        i_rx_data;
  logic              i_rx_ready;
  logic              o_rx_rden;
  logic              o_frame_valid;
  logic [BUF_AW:0]   o_frame_len;
  logic              o_broadcast;
  logic              i_frame_ack;
  logic [BUF_AW-1:0] i_buf_addr;
  logic [7:0]        o_buf_data;
  logic              o_crc_err;
  logic              o_ovf_err;

  modport slave (
    input  i_rx_data, i_rx_ready, i_frame_ack, i_buf_addr,
    output o_rx_rden, o_frame_valid, o_frame_len, o_broadcast,
           o_buf_data, o_crc_err, o_ovf_err
  );

  modport master (
    output i_rx_data, i_rx_ready, i_frame_ack, i_buf_addr,
    input  o_rx_rden, o_frame_valid, o_frame_len, o_broadcast,
           o_buf_data, o_crc_err, o_ovf_err
  );
endinterface

// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU frame receiver. Pulls bytes from the UART controller, delimits
// frames by 3.5-character silence, checks CRC-16/MODBUS and the slave
// address, and holds an accepted frame in a buffer until the engine acks it.
module modbus_rtu_frame_rx #(
  parameter int T35_CYCLES = 175000,
  parameter int BUF_AW     = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_enable,
  input  logic [7:0]                  i_slave_addr,
  modbus_rtu_frame_rx_if.slave        bus
);

  localparam int MAX_LEN = 1 << BUF_AW;
  localparam int TW      = $clog2(T35_CYCLES + 1);
  localparam int LW      = BUF_AW + 1;

  localparam logic [TW-1:0] T35_VAL     = TW'(T35_CYCLES);
  localparam logic [TW-1:0] T35_M1      = TW'(T35_CYCLES - 1);
  localparam logic [LW-1:0] MAX_LEN_VAL = LW'(MAX_LEN);
  localparam logic [LW-1:0] LEN_SAT     = LW'(MAX_LEN + 1);
  localparam logic [LW-1:0] MIN_LEN     = LW'(4);

  typedef enum logic [2:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_RECEIVE,
    ST_CHECK,
    ST_HOLD
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic              r_rx_rden;
  logic [TW-1:0]     r_timer;
  logic [LW-1:0]     r_len;
  logic [15:0]       r_crc;
  logic [7:0]        r_addr_byte;
  logic              r_frame_valid;
  logic [LW-1:0]     r_frame_len;
  logic              r_broadcast;
  logic              r_crc_err;
  logic              r_ovf_err;
  logic [7:0]        r_buf_data;
  logic [7:0]        r_buf [0:MAX_LEN-1];

  logic              w_accept;
  logic              w_silent;
  logic              w_first_byte;
  logic              w_next_byte;
  logic              w_frame_ok;
  logic              w_crc_fail;
  logic              w_ovf_fail;
  logic              w_release;
  logic              w_buf_we;
  logic [BUF_AW-1:0] w_buf_waddr;
  logic [15:0]       w_crc_stage [0:8];

  // A byte is taken in the cycle the consume pulse is high.
  assign w_accept = r_rx_rden;
  assign w_silent = (r_timer == T35_VAL);

  // Byte-wide CRC step, unrolled one bit per stage; a new frame starts from 0xFFFF.
  assign w_crc_stage[0] = (w_first_byte ? 16'hFFFF : r_crc) ^ {8'h00, bus.i_rx_data};
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bit
      assign w_crc_stage[gi+1] = w_crc_stage[gi][0]
                               ? ((w_crc_stage[gi] >> 1) ^ 16'hA001)
                               : (w_crc_stage[gi] >> 1);
    end
  endgenerate

  // Bytes beyond the buffer are counted but never stored.
  assign w_buf_we    = w_first_byte | (w_next_byte & (r_len < MAX_LEN_VAL));
  assign w_buf_waddr = w_first_byte ? '0 : r_len[BUF_AW-1:0];

  // Consume pulse: at most one cycle high, so the controller sees every byte once.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_rx_rden <= 1'b0;
    else       r_rx_rden <= bus.i_rx_ready & ~r_rx_rden;
  end

  // Silence timer: cleared by each accepted byte, saturates at the 3.5-char mark.
  always_ff @(posedge i_clk) begin
    if (i_rst)          r_timer <= '0;
    else if (w_accept)  r_timer <= '0;
    else if (!w_silent) r_timer <= r_timer + TW'(1);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_WAIT_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and per-cycle decisions; disable overrides everything.
  always_comb begin
    w_state_next = r_state;
    w_first_byte = 1'b0;
    w_next_byte  = 1'b0;
    w_frame_ok   = 1'b0;
    w_crc_fail   = 1'b0;
    w_ovf_fail   = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_WAIT_IDLE: begin
        if (w_silent) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_accept) begin
          w_first_byte = 1'b1;
          w_state_next = ST_RECEIVE;
        end
      end
      ST_RECEIVE: begin
        // A byte landing on the last cycle still belongs to this frame.
        w_next_byte = w_accept;
        if (r_timer == T35_M1) w_state_next = ST_CHECK;
      end
      ST_CHECK: begin
        w_state_next = ST_IDLE;
        if (r_len > MAX_LEN_VAL) begin
          w_ovf_fail = 1'b1;
        end else if (r_len < MIN_LEN) begin
          w_state_next = ST_IDLE;
        end else if (r_crc != 16'h0000) begin
          w_crc_fail = 1'b1;
        end else if ((r_addr_byte == i_slave_addr) || (r_addr_byte == 8'h00)) begin
          w_frame_ok   = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.i_frame_ack) begin
          w_release    = 1'b1;
          w_state_next = ST_WAIT_IDLE;
        end
      end
      default: w_state_next = ST_WAIT_IDLE;
    endcase
    if (!i_enable) begin
      w_state_next = ST_WAIT_IDLE;
      w_first_byte = 1'b0;
      w_next_byte  = 1'b0;
      w_frame_ok   = 1'b0;
      w_crc_fail   = 1'b0;
      w_ovf_fail   = 1'b0;
      w_release    = 1'b0;
    end
  end

  // Frame accumulation: length, running CRC and a copy of the address byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len       <= '0;
      r_crc       <= 16'hFFFF;
      r_addr_byte <= 8'h00;
    end else if (w_first_byte) begin
      r_len       <= LW'(1);
      r_crc       <= w_crc_stage[8];
      r_addr_byte <= bus.i_rx_data;
    end else if (w_next_byte) begin
      r_len       <= (r_len == LEN_SAT) ? r_len : r_len + LW'(1);
      r_crc       <= w_crc_stage[8];
    end
  end

  // Result outputs: error pulses last one cycle, the frame is held until ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_frame_valid <= 1'b0;
      r_frame_len   <= '0;
      r_broadcast   <= 1'b0;
      r_crc_err     <= 1'b0;
      r_ovf_err     <= 1'b0;
    end else begin
      r_crc_err <= w_crc_fail;
      r_ovf_err <= w_ovf_fail;
      if (!i_enable || w_release) begin
        r_frame_valid <= 1'b0;
      end else if (w_frame_ok) begin
        r_frame_valid <= 1'b1;
        r_frame_len   <= r_len - LW'(2);
        r_broadcast   <= (r_addr_byte == 8'h00);
      end
    end
  end

  // Buffer write port (no reset so it maps onto block RAM).
  always_ff @(posedge i_clk) begin
    if (w_buf_we) r_buf[w_buf_waddr] <= bus.i_rx_data;
  end

  // Buffer read port with registered output.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_buf_data <= 8'h00;
    else       r_buf_data <= r_buf[bus.i_buf_addr];
  end

  assign bus.o_rx_rden     = r_rx_rden;
  assign bus.o_frame_valid = r_frame_valid;
  assign bus.o_frame_len   = r_frame_len;
  assign bus.o_broadcast   = r_broadcast;
  assign bus.o_buf_data    = r_buf_data;
  assign bus.o_crc_err     = r_crc_err;
  assign bus.o_ovf_err     = r_ovf_err;

endmodule
